// File: rtl/fft_r2sdf_stage.sv
// Parametrised radix-2 DIF single-path-delay-feedback (R2SDF) butterfly stage.
// Optional macro FFT_STAGE_SAT_EN: saturate every narrowing step and raise sticky ovf.
module fft_r2sdf_stage #(
   parameter int W     = 16,
   parameter int TW_W  = 16,
   parameter int LOG2D = 9,
   parameter int SCALE = 1
) (
   input  logic                   clock_c,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   sync_in,
   input  logic                   in_valid,
   input  logic signed [W-1:0]    in_re,
   input  logic signed [W-1:0]    in_im,
   output logic [LOG2D-1:0]       tw_idx,
   input  logic signed [TW_W-1:0] tw_re,
   input  logic signed [TW_W-1:0] tw_im,
   output logic                   out_valid,
   output logic                   sync_out,
   output logic signed [W-1:0]    out_re,
   output logic signed [W-1:0]    out_im,
   output logic                   ovf
);
   localparam int D  = 1 << LOG2D;
   localparam int MW = W + TW_W;
   localparam int PW = W + TW_W + 1;

   // Returns {clip, value}: butterfly sum/diff narrowed from W+1 to W bits.
   function automatic logic [W:0] narrow_bfly(input logic signed [W:0] v);
      logic [W:0] r;
      if (SCALE != 0) begin
         r = {1'b0, v[W:1]};
      end else begin
`ifdef FFT_STAGE_SAT_EN
         if (v[W] != v[W-1]) begin
            r = v[W] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
         end else begin
            r = {1'b0, v[W-1:0]};
         end
`else
         r = {1'b0, v[W-1:0]};
`endif
      end
      return r;
   endfunction

   // Returns {clip, value}: complex-product component >>> (TW_W-1), narrowed to W bits.
   function automatic logic [W:0] narrow_prod(input logic signed [PW-1:0] p);
      logic [W:0] r;
`ifdef FFT_STAGE_SAT_EN
      logic [PW-MW+1:0] hi;
      hi = p[PW-1:MW-2];
      if ((&hi) || !(|hi)) begin
         r = {1'b0, p[MW-2:TW_W-1]};
      end else begin
         r = p[PW-1] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
      end
`else
      r = {1'b0, p[MW-2:TW_W-1]};
`endif
      return r;
   endfunction

   logic [LOG2D:0]      cnt_q, cnt_d, idx_s;
   logic                primed_q, primed_d;
   logic                step_s, resync_s, phase_b_s;
   logic [LOG2D-1:0]    addr_s;
   logic [2*W-1:0]      dly_mem [D];
   logic signed [W-1:0] dly_re_s, dly_im_s;
   logic signed [W:0]   sum_re_s, sum_im_s, dif_re_s, dif_im_s;
   logic [W:0]          nsum_re_s, nsum_im_s, ndif_re_s, ndif_im_s;
   logic                   s1_valid_q, s1_valid_d, s1_sync_q, s1_sync_d, s1_diff_q, s1_diff_d;
   logic signed [W-1:0]    s1_re_q, s1_re_d, s1_im_q, s1_im_d;
   logic signed [TW_W-1:0] s1_twr_q, s1_twr_d, s1_twi_q, s1_twi_d;
   logic                   out_valid_q, out_valid_d, sync_out_q, sync_out_d;
   logic signed [W-1:0]    out_re_q, out_re_d, out_im_q, out_im_d;
   logic signed [MW-1:0]   m_rr_s, m_ii_s, m_ri_s, m_ir_s;
   logic signed [PW-1:0]   p_re_s, p_im_s;
   logic [W:0]             np_re_s, np_im_s;

   // A sync at a non-zero position restarts the frame: this sample becomes index 0.
   assign step_s    = en & in_valid;
   assign resync_s  = sync_in & (cnt_q != {(LOG2D+1){1'b0}});
   assign idx_s     = sync_in ? {(LOG2D+1){1'b0}} : cnt_q;
   assign phase_b_s = idx_s[LOG2D];
   assign addr_s    = idx_s[LOG2D-1:0];
   assign tw_idx    = cnt_q[LOG2D-1:0];

   assign {dly_re_s, dly_im_s} = dly_mem[addr_s];
   assign sum_re_s  = {dly_re_s[W-1], dly_re_s} + {in_re[W-1], in_re};
   assign sum_im_s  = {dly_im_s[W-1], dly_im_s} + {in_im[W-1], in_im};
   assign dif_re_s  = {dly_re_s[W-1], dly_re_s} - {in_re[W-1], in_re};
   assign dif_im_s  = {dly_im_s[W-1], dly_im_s} - {in_im[W-1], in_im};
   assign nsum_re_s = narrow_bfly(sum_re_s);
   assign nsum_im_s = narrow_bfly(sum_im_s);
   assign ndif_re_s = narrow_bfly(dif_re_s);
   assign ndif_im_s = narrow_bfly(dif_im_s);

   assign m_rr_s  = MW'(s1_re_q) * MW'(s1_twr_q);
   assign m_ii_s  = MW'(s1_im_q) * MW'(s1_twi_q);
   assign m_ri_s  = MW'(s1_re_q) * MW'(s1_twi_q);
   assign m_ir_s  = MW'(s1_im_q) * MW'(s1_twr_q);
   assign p_re_s  = {m_rr_s[MW-1], m_rr_s} - {m_ii_s[MW-1], m_ii_s};
   assign p_im_s  = {m_ri_s[MW-1], m_ri_s} + {m_ir_s[MW-1], m_ir_s};
   assign np_re_s = narrow_prod(p_re_s);
   assign np_im_s = narrow_prod(p_im_s);

   // Delay line as a read-before-write circular buffer addressed by frame position.
   always_ff @(posedge clock_c) begin
      if (step_s) begin
         if (phase_b_s) begin
            dly_mem[addr_s] <= {ndif_re_s[W-1:0], ndif_im_s[W-1:0]};
         end else begin
            dly_mem[addr_s] <= {in_re, in_im};
         end
      end
   end

   // Next state: counter, primed flag and both pipeline stages.
   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      s1_valid_d  = s1_valid_q;
      s1_sync_d   = s1_sync_q;
      s1_diff_d   = s1_diff_q;
      s1_re_d     = s1_re_q;
      s1_im_d     = s1_im_q;
      s1_twr_d    = s1_twr_q;
      s1_twi_d    = s1_twi_q;
      out_valid_d = out_valid_q;
      sync_out_d  = sync_out_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      if (en) begin
         s1_valid_d  = 1'b0;
         s1_sync_d   = 1'b0;
         out_valid_d = s1_valid_q;
         sync_out_d  = s1_valid_q & s1_sync_q;
         if (s1_valid_q) begin
            out_re_d = s1_diff_q ? signed'(np_re_s[W-1:0]) : s1_re_q;
            out_im_d = s1_diff_q ? signed'(np_im_s[W-1:0]) : s1_im_q;
         end else begin
            out_re_d = out_re_q;
         end
         if (step_s) begin
            cnt_d = idx_s + {{LOG2D{1'b0}}, 1'b1};
            if (phase_b_s) begin
               s1_valid_d = 1'b1;
               s1_diff_d  = 1'b0;
               s1_sync_d  = (addr_s == {LOG2D{1'b0}});
               s1_re_d    = nsum_re_s[W-1:0];
               s1_im_d    = nsum_im_s[W-1:0];
               primed_d   = primed_q | (addr_s == {LOG2D{1'b1}});
            end else begin
               s1_valid_d = primed_q & ~resync_s;
               s1_diff_d  = 1'b1;
               s1_re_d    = dly_re_s;
               s1_im_d    = dly_im_s;
               s1_twr_d   = tw_re;
               s1_twi_d   = tw_im;
               primed_d   = primed_q & ~resync_s;
            end
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= {(LOG2D+1){1'b0}};
         primed_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_sync_q   <= 1'b0;
         s1_diff_q   <= 1'b0;
         s1_re_q     <= {W{1'b0}};
         s1_im_q     <= {W{1'b0}};
         s1_twr_q    <= {TW_W{1'b0}};
         s1_twi_q    <= {TW_W{1'b0}};
         out_valid_q <= 1'b0;
         sync_out_q  <= 1'b0;
         out_re_q    <= {W{1'b0}};
         out_im_q    <= {W{1'b0}};
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         s1_valid_q  <= s1_valid_d;
         s1_sync_q   <= s1_sync_d;
         s1_diff_q   <= s1_diff_d;
         s1_re_q     <= s1_re_d;
         s1_im_q     <= s1_im_d;
         s1_twr_q    <= s1_twr_d;
         s1_twi_q    <= s1_twi_d;
         out_valid_q <= out_valid_d;
         sync_out_q  <= sync_out_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sync_out  = sync_out_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

`ifdef FFT_STAGE_SAT_EN
   logic ovf_q, ovf_d;
   assign ovf_d = ovf_q
                | (step_s & phase_b_s & (nsum_re_s[W] | nsum_im_s[W] | ndif_re_s[W] | ndif_im_s[W]))
                | (en & s1_valid_q & s1_diff_q & (np_re_s[W] | np_im_s[W]));

   // Sticky clip flag, cleared only by reset.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Self-checking bench for fft_r2sdf_stage (D=4): directed table plus random traffic
// against a frame-level reference model; SCALE=0 and SCALE=1 instances share the stimulus.
module tb_fft_r2sdf_stage;
   localparam int D = 4;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync_in = 1'b0, in_valid = 1'b0;
   logic signed [15:0] in_re = 16'sd0, in_im = 16'sd0;
   logic [1:0]         tw_idx0, tw_idx1;
   logic signed [15:0] tw_re0, tw_im0, tw_re1, tw_im1;
   logic               ov0, sy0, ovf0, ov1, sy1, ovf1;
   logic signed [15:0] ore0, oim0, ore1, oim1;
   logic signed [15:0] rom_re [D];
   logic signed [15:0] rom_im [D];
   logic               en_edge = 1'b0, mon_on = 1'b0;

   int vec_cnt = 0, err_cnt = 0;

   typedef struct {int re; int im; bit sy;} samp_t;
   samp_t q0[$], q1[$];
   int    got0[$], got1[$];
   int    mpos;
   bit    mprimed;
   int    xa_re [D], xa_im [D];
   int    pd_re [2][D], pd_im [2][D];
   bit    mclip [2];

   typedef struct {bit v; int re; bit ev; int e0; int e1; bit es;} vec_t;
   vec_t tbl [14];

   always #5 clk = ~clk;

   assign tw_re0 = rom_re[tw_idx0];
   assign tw_im0 = rom_im[tw_idx0];
   assign tw_re1 = rom_re[tw_idx1];
   assign tw_im1 = rom_im[tw_idx1];

   fft_r2sdf_stage #(.W(16), .TW_W(16), .LOG2D(2), .SCALE(0)) u0 (
      .clock_c(clk), .reset_n(rst_n), .en(en), .sync_in(sync_in), .in_valid(in_valid),
      .in_re(in_re), .in_im(in_im), .tw_idx(tw_idx0), .tw_re(tw_re0), .tw_im(tw_im0),
      .out_valid(ov0), .sync_out(sy0), .out_re(ore0), .out_im(oim0), .ovf(ovf0));

   fft_r2sdf_stage #(.W(16), .TW_W(16), .LOG2D(2), .SCALE(1)) u1 (
      .clock_c(clk), .reset_n(rst_n), .en(en), .sync_in(sync_in), .in_valid(in_valid),
      .in_re(in_re), .in_im(in_im), .tw_idx(tw_idx1), .tw_re(tw_re1), .tw_im(tw_im1),
      .out_valid(ov1), .sync_out(sy1), .out_re(ore1), .out_im(oim1), .ovf(ovf1));

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Reference arithmetic: narrow to 16 bits (saturating when the macro is set).
   function automatic int nar(input longint v, input int s);
      logic signed [15:0] t;
`ifdef FFT_STAGE_SAT_EN
      if (v > 32767) begin mclip[s] = 1'b1; return 32767; end
      if (v < -32768) begin mclip[s] = 1'b1; return -32768; end
`endif
      t = v[15:0];
      return int'(t);
   endfunction

   function automatic int bfly(input int a, input int b, input int s, input bit neg);
      longint x;
      x = neg ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
      if (s == 1) return int'(x >>> 1);
      return nar(x, s);
   endfunction

   task automatic model_reset();
      q0.delete(); q1.delete();
      mpos = 0; mprimed = 1'b0;
   endtask

   // Frame-level model: first half buffered, second half emits sums, diffs emerge next frame.
   task automatic model_step(input bit s_in, input int re, input int im);
      int n;
      longint pr, pi;
      samp_t e;
      if (s_in && mpos != 0) mprimed = 1'b0;
      if (s_in) mpos = 0;
      n = mpos % D;
      for (int s = 0; s < 2; s++) begin
         if (mpos < D) begin
            if (mprimed) begin
               pr = (longint'(pd_re[s][n]) * rom_re[n] - longint'(pd_im[s][n]) * rom_im[n]) >>> 15;
               pi = (longint'(pd_re[s][n]) * rom_im[n] + longint'(pd_im[s][n]) * rom_re[n]) >>> 15;
               e.re = nar(pr, s); e.im = nar(pi, s); e.sy = 1'b0;
               if (s == 0) q0.push_back(e); else q1.push_back(e);
            end
         end else begin
            e.re = bfly(xa_re[n], re, s, 1'b0);
            e.im = bfly(xa_im[n], im, s, 1'b0);
            e.sy = (n == 0);
            if (s == 0) q0.push_back(e); else q1.push_back(e);
            pd_re[s][n] = bfly(xa_re[n], re, s, 1'b1);
            pd_im[s][n] = bfly(xa_im[n], im, s, 1'b1);
         end
      end
      if (mpos < D) begin
         xa_re[n] = re; xa_im[n] = im;
      end else if (n == D - 1) begin
         mprimed = 1'b1;
      end
      mpos = (mpos + 1) % (2 * D);
   endtask

   task automatic cyc(input bit e, input bit v, input bit s, input int re, input int im);
      en = e; in_valid = v; sync_in = s; in_re = 16'(re); in_im = 16'(im);
      if (e && v) model_step(s, re, im);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; sync_in = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mclip[0] = 1'b0; mclip[1] = 1'b0;
      got0.delete(); got1.delete();
   endtask

   task automatic mon_one(input int s, input logic v, input logic sy,
                          input logic signed [15:0] re, input logic signed [15:0] im);
      samp_t e;
      if (v) begin
         if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            vec_cnt++; err_cnt++;
            $display("FAIL unexpected_out%0d: got re=%0d, want no output", s, re);
         end else begin
            if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("out_re%0d", s), re, e.re);
            chk($sformatf("out_im%0d", s), im, e.im);
            chk($sformatf("sync_out%0d", s), sy, e.sy);
            if (s == 0) got0.push_back(int'(re)); else got1.push_back(int'(re));
         end
      end
   endtask

   always @(posedge clk) en_edge <= en;

   // Outputs count only after an edge where the stage was enabled.
   always @(negedge clk) begin
      if (mon_on && rst_n && en_edge) begin
         mon_one(0, ov0, sy0, ore0, oim0);
         mon_one(1, ov1, sy1, ore1, oim1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int xs [12];
      logic signed [15:0] r16a, r16b;
      for (int i = 0; i < D; i++) begin rom_re[i] = 16'sd32767; rom_im[i] = 16'sd0; end
      for (int i = 0; i < 12; i++) xs[i] = 0;
      xs[0] = 100; xs[4] = 20;
      for (int k = 0; k < 14; k++) begin
         tbl[k].v = (k < 12); tbl[k].re = (k < 12) ? xs[k] : 0;
         tbl[k].ev = (k >= 5 && k <= 12); tbl[k].e0 = 0; tbl[k].e1 = 0; tbl[k].es = (k == 5);
      end
      tbl[5].e0 = 120; tbl[5].e1 = 60; tbl[9].e0 = 79; tbl[9].e1 = 39;

      // reset state
      @(negedge clk);
      chk("rst_valid0", ov0, 0); chk("rst_valid1", ov1, 0);
      chk("rst_sync0", sy0, 0);  chk("rst_re0", ore0, 0);
      chk("rst_im0", oim0, 0);   chk("rst_re1", ore1, 0);
      chk("rst_ovf0", ovf0, 0);  chk("rst_ovf1", ovf1, 0);
      do_reset();

      // directed table, cycle exact
      for (int k = 0; k < 14; k++) begin
         cyc(1'b1, tbl[k].v, 1'b0, tbl[k].re, 0);
         chk($sformatf("tbl%0d_valid0", k), ov0, tbl[k].ev);
         chk($sformatf("tbl%0d_valid1", k), ov1, tbl[k].ev);
         if (tbl[k].ev) begin
            chk($sformatf("tbl%0d_re0", k), ore0, tbl[k].e0);
            chk($sformatf("tbl%0d_re1", k), ore1, tbl[k].e1);
            chk($sformatf("tbl%0d_im0", k), oim0, 0);
            chk($sformatf("tbl%0d_im1", k), oim1, 0);
            chk($sformatf("tbl%0d_sync0", k), sy0, tbl[k].es);
            chk($sformatf("tbl%0d_sync1", k), sy1, tbl[k].es);
         end
      end

      // gapped stream with an en-low window
      do_reset();
      mon_on = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 0, 0);
         if (i == 5) for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 1'b0, 777, 5);
         cyc(1'b1, 1'b1, 1'b0, xs[i], 0);
      end
      for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("gap_count0", got0.size(), 8);
      for (int k = 0; k < 8 && k < got0.size(); k++) chk($sformatf("gap_re0_%0d", k), got0[k], tbl[k+5].e0);

      // resync at position 2 of the second frame
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 10 * (i + 1), -i);
      cyc(1'b1, 1'b1, 1'b0, 5, 1);
      cyc(1'b1, 1'b1, 1'b0, 6, 2);
      cyc(1'b1, 1'b1, 1'b1, 300, 7);
      for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 40 * i, 3 * i);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
      for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("resync_count0", got0.size(), 14);

      // overflow: a = b = 30000
      do_reset();
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, (i == 0 || i == 4) ? 30000 : 0, 0);
      for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      if (got0.size() > 0) begin
`ifdef FFT_STAGE_SAT_EN
         chk("sat_sum0", got0[0], 32767);
         chk("sat_ovf0", ovf0, 1);
`else
         chk("wrap_sum0", got0[0], -5536);
         chk("wrap_ovf0", ovf0, 0);
`endif
      end else begin
         chk("ovf_test_outputs", got0.size(), 8);
      end
      if (got1.size() > 0) chk("sat_sum1", got1[0], 30000);
      chk("sat_ovf1", ovf1, 0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
`ifdef FFT_STAGE_SAT_EN
      chk("sticky_ovf0", ovf0, 1);
`else
      chk("sticky_ovf0", ovf0, 0);
`endif

      // reset pulsed in the middle of phase B
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1000 + i, -i);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid0", ov0, 0); chk("midrst_valid1", ov1, 0);
      chk("midrst_re0", ore0, 0);   chk("midrst_im1", oim1, 0);
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 50 * i, 7 - i);
      for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("midrst_count0", got0.size(), 4);

      // random traffic with random twiddles
      do_reset();
      for (int i = 0; i < D; i++) begin
         rom_re[i] = 16'($urandom); rom_im[i] = 16'($urandom);
      end
      for (int c = 0; c < 500; c++) begin
         r16a = 16'($urandom); r16b = 16'($urandom);
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
             int'(r16a), int'(r16b));
      end
      for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("rand_drain0", q0.size(), 0);
      chk("rand_drain1", q1.size(), 0);
      chk("rand_ovf0", ovf0, mclip[0]);
      chk("rand_ovf1", ovf1, mclip[1]);
      mon_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
